// File: rtl/kf_ctrl_pkg.sv
// Shared definitions for the Kalman filter run controller: FSM states and
// the microinstruction control opcodes also used by the sequencer and assembler.
package kf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAITM = 3'd3,
    ST_CONT  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;

  // Host-facing resting states: ROM writes and go are honoured only here.
  function automatic logic is_idle(input state_t s);
    return (s == ST_IDLE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/kf_wdog.sv
// Stall watchdog: counts consecutive enabled cycles with an unchanged PC and
// flags expiry once the count reaches LIMIT-1.
module kf_wdog #(
  parameter int PC_W  = 8,
  parameter int LIMIT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  output logic            expire
);

  localparam int CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_r;
  logic [PC_W-1:0]  last_pc_r;

  // Stall counter; holds its value while neither cleared nor enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= {CNT_W{1'b0}};
      last_pc_r <= {PC_W{1'b0}};
    end else if (clear) begin
      count_r   <= {CNT_W{1'b0}};
      last_pc_r <= pc;
    end else if (enable) begin
      last_pc_r <= pc;
      count_r   <= (pc == last_pc_r) ? count_r + CNT_W'(1) : {CNT_W{1'b0}};
    end
  end

  assign expire = enable & (count_r == LAST);

endmodule

// File: rtl/kf_run_ctrl.sv
// Run-level controller around the Kalman microcode sequencer: gates ROM loads,
// starts each iteration, serves WAIT with one measurement, counts iterations.
module kf_run_ctrl
  import kf_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 8,
  parameter int ROM_DW     = 16,
  parameter int ITER_W     = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic              meas_valid,
  input  logic [DATA_W-1:0] meas_data,
  output logic              meas_ready,
  output logic [DATA_W-1:0] z_data,
  output logic              z_load,
  output logic              seq_start,
  output logic              seq_continue,
  input  logic              seq_ready,
  input  logic [1:0]        seq_ctl_c,
  input  logic [PC_W-1:0]   seq_pc,
  input  logic              host_rom_we,
  input  logic [PC_W-1:0]   host_rom_waddr,
  input  logic [ROM_DW-1:0] host_rom_wdata,
  output logic              rom_we,
  output logic [PC_W-1:0]   rom_waddr,
  output logic [ROM_DW-1:0] rom_wdata,
  output logic              rom_wr_rej,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              timeout_err
);

  state_t            state_r, state_nxt_s;
  logic [ITER_W-1:0] iter_r, cfg_r, iter_inc_s;
  logic [DATA_W-1:0] z_data_r;
  logic              z_load_r, done_r, rej_r, tout_r;
  logic              idle_s, go_s, accept_s, complete_s, last_s, wd_expire_s;

  assign idle_s     = is_idle(state_r);
  assign go_s       = idle_s & go & ~abort;
  assign accept_s   = meas_ready & meas_valid;
  assign complete_s = (state_r == ST_RUN) & seq_ready & ~abort;
  assign iter_inc_s = iter_r + ITER_W'(1);
  assign last_s     = (cfg_r != {ITER_W{1'b0}}) & (iter_inc_s == cfg_r);

  kf_wdog #(.PC_W(PC_W), .LIMIT(WDOG_LIMIT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (idle_s | (state_r == ST_START)),
    .enable (state_r == ST_RUN),
    .pc     (seq_pc),
    .expire (wd_expire_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic; abort overrides everything, completion beats the watchdog.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_ERROR: state_nxt_s = go ? ST_START : state_r;
        ST_START:          state_nxt_s = ST_RUN;
        ST_RUN: begin
          if (seq_ready)                   state_nxt_s = last_s ? ST_IDLE : ST_START;
          else if (seq_ctl_c == OP_WAIT)   state_nxt_s = ST_WAITM;
          else if (wd_expire_s)            state_nxt_s = ST_ERROR;
          else                             state_nxt_s = ST_RUN;
        end
        ST_WAITM:          state_nxt_s = meas_valid ? ST_CONT : ST_WAITM;
        ST_CONT:           state_nxt_s = ST_RUN;
        default:           state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Sequencer handshake outputs, all forced low in an abort cycle.
  always_comb begin
    seq_start    = 1'b0;
    seq_continue = 1'b0;
    meas_ready   = 1'b0;
    if (abort) begin
      seq_start    = 1'b0;
      seq_continue = 1'b0;
      meas_ready   = 1'b0;
    end else begin
      case (state_r)
        ST_START: seq_start    = 1'b1;
        ST_WAITM: meas_ready   = 1'b1;
        ST_CONT:  seq_continue = 1'b1;
        default:  seq_start    = 1'b0;
      endcase
    end
  end

  // Run bookkeeping, measurement capture and single-cycle status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_r   <= {ITER_W{1'b0}};
      cfg_r    <= {ITER_W{1'b0}};
      z_data_r <= {DATA_W{1'b0}};
      z_load_r <= 1'b0;
      done_r   <= 1'b0;
      rej_r    <= 1'b0;
      tout_r   <= 1'b0;
    end else begin
      z_load_r <= accept_s;
      done_r   <= complete_s & last_s;
      rej_r    <= host_rom_we & ~idle_s;
      if (accept_s) z_data_r <= meas_data;
      if (go_s) begin
        cfg_r  <= cfg_iters;
        iter_r <= {ITER_W{1'b0}};
        tout_r <= 1'b0;
      end else begin
        if (complete_s) iter_r <= iter_inc_s;
        if ((state_r == ST_RUN) && (state_nxt_s == ST_ERROR)) tout_r <= 1'b1;
      end
    end
  end

  assign rom_we      = host_rom_we & idle_s;
  assign rom_waddr   = host_rom_waddr;
  assign rom_wdata   = host_rom_wdata;
  assign rom_wr_rej  = rej_r;
  assign busy        = ~idle_s;
  assign done        = done_r;
  assign iter_count  = iter_r;
  assign z_data      = z_data_r;
  assign z_load      = z_load_r;
  assign timeout_err = tout_r;

endmodule

// File: tb/tb_kf_run_ctrl.sv
// Scoreboard bench for kf_run_ctrl with a small behavioural sequencer model.
module tb_kf_run_ctrl;
  import kf_ctrl_pkg::*;

  localparam int DATA_W = 32, PC_W = 8, ROM_DW = 16, ITER_W = 16;

  logic clk = 1'b0, rst = 1'b1, go = 1'b0, abort = 1'b0;
  logic [ITER_W-1:0] cfg_iters = '0;
  logic meas_valid = 1'b0;
  logic [DATA_W-1:0] meas_data = '0;
  logic meas_ready, z_load, seq_start, seq_continue, seq_ready;
  logic [DATA_W-1:0] z_data;
  logic [1:0] seq_ctl_c;
  logic [PC_W-1:0] seq_pc;
  logic host_rom_we = 1'b0;
  logic [PC_W-1:0] host_rom_waddr = '0;
  logic [ROM_DW-1:0] host_rom_wdata = '0;
  logic rom_we, rom_wr_rej, busy, done, timeout_err;
  logic [PC_W-1:0] rom_waddr;
  logic [ROM_DW-1:0] rom_wdata;
  logic [ITER_W-1:0] iter_count;

  kf_run_ctrl #(.DATA_W(DATA_W), .PC_W(PC_W), .ROM_DW(ROM_DW), .ITER_W(ITER_W),
                .WDOG_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .cfg_iters(cfg_iters),
    .meas_valid(meas_valid), .meas_data(meas_data), .meas_ready(meas_ready),
    .z_data(z_data), .z_load(z_load), .seq_start(seq_start),
    .seq_continue(seq_continue), .seq_ready(seq_ready), .seq_ctl_c(seq_ctl_c),
    .seq_pc(seq_pc), .host_rom_we(host_rom_we), .host_rom_waddr(host_rom_waddr),
    .host_rom_wdata(host_rom_wdata), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .rom_wr_rej(rom_wr_rej), .busy(busy), .done(done),
    .iter_count(iter_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Sequencer model running program {step, wait, step, halt}; frozen pins pc at 2.
  logic run_m = 1'b0, frozen = 1'b0;
  logic [PC_W-1:0] pc_m = '0;

  function automatic logic [1:0] prog_op(input logic [PC_W-1:0] p);
    case (p)
      8'd0:    return OP_STEP;
      8'd1:    return OP_WAIT;
      8'd2:    return OP_STEP;
      default: return OP_HALT;
    endcase
  endfunction

  always @(posedge clk) begin
    if (seq_start) begin
      run_m <= 1'b1;
      pc_m  <= '0;
    end else if (run_m && !frozen) begin
      case (prog_op(pc_m))
        OP_STEP: pc_m <= pc_m + 8'd1;
        OP_WAIT: if (seq_continue) pc_m <= pc_m + 8'd1;
        default: run_m <= 1'b0;
      endcase
    end
  end

  assign seq_ready = frozen ? 1'b0 : ~run_m;
  assign seq_ctl_c = (frozen || !run_m) ? OP_STEP : prog_op(pc_m);
  assign seq_pc    = frozen ? 8'd2 : pc_m;

  // Scoreboard
  typedef enum int {EV_START, EV_ZLOAD, EV_CONT, EV_DONE, EV_REJ} ev_t;
  typedef struct { ev_t kind; logic [31:0] data; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input ev_t k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic pop_check(input ev_t k, input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event %s: got %h, want no event", k.name(), act);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.data !== act) begin
        n_bad++;
        $display("FAIL event_order: got %s %h, want %s %h", k.name(), act, e.kind.name(), e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_wr_rej)   pop_check(EV_REJ, 32'd0);
      if (seq_start)    pop_check(EV_START, 32'(iter_count));
      if (z_load)       pop_check(EV_ZLOAD, z_data);
      if (seq_continue) pop_check(EV_CONT, 32'd0);
      if (done)         pop_check(EV_DONE, 32'(iter_count));
    end
  end

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic wait_meas_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (meas_ready) begin
        ok = 1'b1;
        return;
      end
    end
    check("meas_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_meas(input logic [31:0] d, input int dly);
    bit ok;
    wait_meas_ready(ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      meas_valid = 1'b1;
      meas_data  = d;
      @(posedge clk); #1 meas_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state, during and after reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 32'd0);
    check("rst_iter", iter_count, 32'd0);
    check("rst_zdata", z_data, 32'd0);
    check("rst_tout", timeout_err, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {seq_start, seq_continue, meas_ready, z_load, done, rom_wr_rej, rom_we}, 32'd0);

    // Idle ROM write passes through the same cycle
    host_rom_we = 1'b1; host_rom_waddr = 8'd3; host_rom_wdata = 16'h3A70;
    #1;
    check("rom_we_idle", rom_we, 32'd1);
    check("rom_waddr", rom_waddr, 32'd3);
    check("rom_wdata", rom_wdata, 32'h3A70);
    @(negedge clk);
    host_rom_we = 1'b0;
    check("rom_rej_idle", rom_wr_rej, 32'd0);

    // Measurement offered while idle is not consumed
    meas_valid = 1'b1; meas_data = 32'h1234_5678;
    #1 check("meas_ready_idle", meas_ready, 32'd0);
    repeat (2) @(negedge clk);
    meas_valid = 1'b0;

    // Single iteration
    cfg_iters = 16'd1;
    push(EV_START, 32'd0); push(EV_ZLOAD, 32'hDEAD_BEEF); push(EV_CONT, 32'd0); push(EV_DONE, 32'd1);
    pulse_go();
    do_meas(32'hDEAD_BEEF, 3);
    wait_idle();
    check("single_iter", iter_count, 32'd1);
    check("single_zdata", z_data, 32'hDEAD_BEEF);
    drain("single_drain");

    // Three iterations
    cfg_iters = 16'd3;
    push(EV_START, 32'd0); push(EV_ZLOAD, 32'h1111_0001); push(EV_CONT, 32'd0);
    push(EV_START, 32'd1); push(EV_ZLOAD, 32'h2222_0002); push(EV_CONT, 32'd0);
    push(EV_START, 32'd2); push(EV_ZLOAD, 32'h3333_0003); push(EV_CONT, 32'd0);
    push(EV_DONE, 32'd3);
    pulse_go();
    do_meas(32'h1111_0001, 0);
    do_meas(32'h2222_0002, 1);
    do_meas(32'h3333_0003, 2);
    wait_idle();
    check("multi_iter", iter_count, 32'd3);
    drain("multi_drain");

    // Watchdog with frozen sequencer plus a rejected ROM write mid-run
    frozen = 1'b1;
    cfg_iters = 16'd1;
    push(EV_START, 32'd0); push(EV_REJ, 32'd0);
    pulse_go();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (i == 3) begin
        host_rom_we = 1'b1; host_rom_waddr = 8'd3; host_rom_wdata = 16'h3A70;
        #1 check("rom_we_busy", rom_we, 32'd0);
      end else if (i == 4) begin
        host_rom_we = 1'b0;
      end
    end
    check("wdog_busy_cycles", n, 32'd17);
    check("wdog_tout", timeout_err, 32'd1);
    drain("wdog_drain");
    frozen = 1'b0;
    push(EV_START, 32'd0); push(EV_ZLOAD, 32'h0BAD_F00D); push(EV_CONT, 32'd0); push(EV_DONE, 32'd1);
    pulse_go();
    @(negedge clk);
    check("wdog_tout_cleared", timeout_err, 32'd0);
    do_meas(32'h0BAD_F00D, 1);
    wait_idle();
    drain("restart_drain");

    // Abort in WAITM with a measurement offered the same cycle
    begin
      bit ok;
      push(EV_START, 32'd0);
      pulse_go();
      wait_meas_ready(ok);
      abort = 1'b1; meas_valid = 1'b1; meas_data = 32'h5555_AAAA;
      #1;
      check("abort_meas_ready", meas_ready, 32'd0);
      check("abort_continue", seq_continue, 32'd0);
      @(posedge clk); #1 abort = 1'b0; meas_valid = 1'b0;
      @(negedge clk);
      check("abort_idle", busy, 32'd0);
      check("abort_iter_held", iter_count, 32'd0);
      check("abort_zdata_kept", z_data, 32'h0BAD_F00D);
      drain("abort_drain");
    end
    push(EV_START, 32'd0); push(EV_ZLOAD, 32'h7777_0007); push(EV_CONT, 32'd0); push(EV_DONE, 32'd1);
    pulse_go();
    do_meas(32'h7777_0007, 0);
    wait_idle();
    drain("post_abort_drain");

    // Free-running, then asynchronous reset in the second iteration
    cfg_iters = 16'd0;
    push(EV_START, 32'd0); push(EV_ZLOAD, 32'hCAFE_0001); push(EV_CONT, 32'd0); push(EV_START, 32'd1);
    pulse_go();
    do_meas(32'hCAFE_0001, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    @(posedge clk); #2;
    check("prerst_busy", busy, 32'd1);
    check("prerst_iter", iter_count, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 32'd0);
    check("rst_mid_iter", iter_count, 32'd0);
    check("rst_mid_zdata", z_data, 32'd0);
    check("rst_mid_outs", {seq_start, seq_continue, meas_ready, z_load, done, rom_wr_rej, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_stays_idle", busy, 32'd0);
    check("final_queue", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
